bus_mux_rr: RTL and testbench
=============================

# bus_mux_rr

Registered, parametrised N-channel bus multiplexer for the CPU datapath, successor to the fixed 4x16 combinational mux. It selects one of CHANNELS valid/ready sources either by an explicit select or by round-robin arbitration, and holds the winning word in a single output register stage with full backpressure. It sits between datapath sources (register file ports, ALU result, immediate, memory read data) and any consumer that can stall.

## Interface
- WIDTH, 16, data width per channel
- CHANNELS, 4, number of input channels, 2..16
- SEL_W, $clog2(CHANNELS), derived localparam, select and channel-ID width

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel valid
- in_ready  out  CHANNELS  per-channel ready; at most one bit high
- rr_en  in  1  1 = round-robin arbitration, 0 = explicit select
- sel  in  SEL_W  channel chosen when rr_en=0
- out_data  out  WIDTH  registered selected word
- out_chan  out  SEL_W  channel that sourced out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts out_data

## Operation
- load_en = !out_valid || out_ready. Output register loads when load_en and a grant exists.
- Fixed mode (rr_en=0): grant = sel if sel < CHANNELS and in_valid[sel]; else no grant. Other channels never granted.
- Round-robin mode (rr_en=1): search channels ptr+1, ptr+2, … modulo CHANNELS; first with in_valid high wins.
- in_ready[i] = load_en && grant==i. Transfer on channel i when in_valid[i] && in_ready[i].
- On transfer: out_data <= in_data[i], out_chan <= i, out_valid <= 1, and ptr <= i (ptr updates in both modes).
- If out_valid && out_ready and no grant: out_valid <= 0; out_data, out_chan hold.
- If out_valid && !out_ready: all in_ready low, out_data/out_chan/out_valid hold.
- rr_en or sel may change any cycle; takes effect on the same cycle's grant computation.
- Sources must hold in_data/in_valid until accepted; block does not check this.

## Timing
- Reset (async assert, sync release via clk): out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1 (channel 0 has first priority), in_ready follows combinationally (load_en=1).
- Latency: 1 cycle from transfer edge to out_valid.
- Throughput: one word per cycle while out_ready stays high.
- in_ready is combinational from out_ready, out_valid, in_valid, rr_en, sel, ptr; out_* are registered only.
- Reset mid-stream: in-flight word dropped, out_valid falls immediately, ptr returns to CHANNELS-1.
- sel >= CHANNELS (non-power-of-two CHANNELS): no grant, no transfer, no error flag.
- Simultaneous drain and load in the same edge: new word replaces old, out_valid stays 1.

## Structure
- Shared package cpu_bus_pkg: default data width constant (16) and the flattened-bus slice convention; no typedefs needed beyond that.
- One sub-module: rr_arbiter (req CHANNELS, ptr SEL_W -> grant_valid, grant_id); purely combinational, reused by future bus arbiters.
- Top module holds mode select, load_en, ptr register and output register.

## Test plan
- Reset: rst_n=0 mid-run with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately; after release all four valid with rr_en=1 -> channel 0 granted first.
- Fixed mode: rr_en=0, sel=2, in_data ch2=0xBEEF, all valid, out_ready=1 -> only in_ready[2] high, next cycle out_data=0xBEEF, out_chan=2.
- Round-robin fairness: rr_en=1, all four valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,… one per cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready all 0, out_data stable; out_ready=1 -> next word loads same edge, out_valid stays 1.
- Sparse requests: rr_en=1, ptr=1, only ch0 and ch3 valid -> ch3 granted, then ch0.
- CHANNELS=3, WIDTH=8 build: sel=3 with all valid -> no grant, out_valid falls after drain.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared constants for CPU datapath buses.
//               Flattened multi-channel buses carry channel i in bits
//               [i*WIDTH +: WIDTH]; slice_lsb() returns that base bit.
// Contents    : c_default_width - default datapath word width (16)
//               slice_lsb()     - LSB position of a channel in a flat bus
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

  localparam int c_default_width = 16;

  // Base bit of channel 'chan' in a flattened bus of 'width'-bit words.
  function automatic int slice_lsb(input int chan, input int width);
    return chan * width;
  endfunction

endpackage : cpu_bus_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin arbiter. Searches the
//               requests starting at ptr+1 and wrapping modulo CHANNELS;
//               the first asserted request wins. ptr itself is searched last.
// Ports       : req         in  CHANNELS  request vector
//               ptr         in  SEL_W     last granted channel (< CHANNELS)
//               grant_valid out 1         some request was found
//               grant_id    out SEL_W     winning channel (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                grant_valid,
  output logic [SEL_W-1:0]    grant_id
);

  logic [SEL_W-1:0] w_idx;

  // Walk from the lowest-priority offset (CHANNELS, i.e. ptr itself) down to
  // the highest (ptr+1); later hits overwrite earlier ones, so the nearest
  // request after ptr ends up as the grant without needing an early exit.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    w_idx       = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      w_idx = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (req[w_idx]) begin
        grant_valid = 1'b1;
        grant_id    = w_idx;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bus_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_mux_rr
// Description : Registered N-channel valid/ready bus multiplexer. Picks one
//               source by explicit select (rr_en=0) or round-robin (rr_en=1)
//               and holds the winning word in one output register stage
//               with full backpressure.
// Ports       : clk        in  1               rising-edge clock
//               rst_n      in  1               async active-low reset
//               in_data    in  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//               in_valid   in  CHANNELS        per-channel valid
//               in_ready   out CHANNELS        per-channel ready (one-hot/0)
//               rr_en      in  1               1=round-robin, 0=explicit sel
//               sel        in  SEL_W           channel used when rr_en=0
//               out_data   out WIDTH           registered selected word
//               out_chan   out SEL_W           channel that sourced out_data
//               out_valid  out 1               output register holds a word
//               out_ready  in  1               consumer accepts out_data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mux_rr
  import cpu_bus_pkg::*;
#(
  parameter  int WIDTH    = c_default_width,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      rr_en,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_ptr;

  // --------------------------------------------------------------------------
  // Grant computation
  // --------------------------------------------------------------------------
  logic             w_load_en;
  logic             w_rr_valid;
  logic [SEL_W-1:0] w_rr_id;
  logic             w_fix_valid;
  logic             w_grant_valid;
  logic [SEL_W-1:0] w_grant_id;
  logic [WIDTH-1:0] w_grant_data;

  // The register can take a new word when empty or when its word drains now.
  assign w_load_en = !r_out_valid || out_ready;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant_valid (w_rr_valid),
    .grant_id    (w_rr_id)
  );

  always_comb begin
    // With a non-power-of-two channel count, sel can name a channel that
    // does not exist; that simply yields no grant.
    w_fix_valid = 1'b0;
    if (int'(sel) < CHANNELS) begin
      w_fix_valid = in_valid[sel];
    end

    w_grant_valid = rr_en ? w_rr_valid : w_fix_valid;
    w_grant_id    = rr_en ? w_rr_id    : sel;
  end

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant_id == SEL_W'(i)) begin
        w_grant_data = in_data[slice_lsb(i, WIDTH) +: WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
    assign in_ready[gi] = w_load_en && w_grant_valid && (w_grant_id == SEL_W'(gi));
  end

  // --------------------------------------------------------------------------
  // Output register and round-robin pointer
  // --------------------------------------------------------------------------
  // Reset ptr to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= SEL_W'(CHANNELS - 1);
    end else if (w_load_en) begin
      if (w_grant_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_chan  <= w_grant_id;
        r_ptr       <= w_grant_id;
      end else begin
        // Drained with nothing to replace it; data/chan keep the last word.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule : bus_mux_rr
`default_nettype wire

// File: tb/tb_bus_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mux_rr
// Description : Directed self-checking bench for bus_mux_rr. Instance u_dut4
//               is the default 4x16 build; u_dut3 is a 3-channel, 8-bit
//               build used for the out-of-range select case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mux_rr;

  logic        clk;
  logic        rst_n;

  // 4-channel, 16-bit instance
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        rr_en;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  // 3-channel, 8-bit instance
  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid;
  logic [2:0]  d3_in_ready;
  logic        d3_rr_en;
  logic [1:0]  d3_sel;
  logic [7:0]  d3_out_data;
  logic [1:0]  d3_out_chan;
  logic        d3_out_valid;
  logic        d3_out_ready;

  int checks;
  int errors;

  bus_mux_rr #(.WIDTH(16), .CHANNELS(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  bus_mux_rr #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .rr_en     (d3_rr_en),
    .sel       (d3_sel),
    .out_data  (d3_out_data),
    .out_chan  (d3_out_chan),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    in_valid  = 4'b0000;
    rr_en     = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h c=%0d, expected v=0 d=0000 c=0",
               out_valid, out_data, out_chan);
    end
    rst_n = 1'b1;
    tick();
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got in_ready=%b expected 0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 16'hA000) begin
      errors++;
      $display("FAIL reset_first_word: got v=%b c=%0d d=%h expected v=1 c=0 d=a000",
               out_valid, out_chan, out_data);
    end
    tick();  // ch1 loaded, ptr=1
    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%b d=%h c=%0d expected v=0 d=0000 c=0",
               out_valid, out_data, out_chan);
    end
    #2;
    rst_n = 1'b1;
    #1;
    // ptr back to 3, so channel 0 is first again
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ptr_restore: got in_ready=%b expected 0001", in_ready);
    end
    in_valid = 4'b0000;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_fixed();
    do_reset();
    in_data   = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    in_valid  = 4'b1111;
    rr_en     = 1'b0;
    sel       = 2'd2;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_ready: got in_ready=%b expected 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL fixed_word: got v=%b d=%h c=%0d expected v=1 d=beef c=2",
               out_valid, out_data, out_chan);
    end
    // Selected channel not valid: no grant, register drains.
    sel      = 2'd3;
    in_valid = 4'b0111;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_sel_invalid_ready: got in_ready=%b expected 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'hBEEF || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL fixed_drain_hold: got v=%b d=%h c=%0d expected v=0 d=beef c=2",
               out_valid, out_data, out_chan);
    end
    in_valid = 4'b0000;
  endtask

  // --------------------------------------------------------------------------
  // Leaves ch1 as the last loaded word (ptr=1), out_valid=1.
  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [15:0] exp_data;
    do_reset();
    in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    in_valid  = 4'b1111;
    rr_en     = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy  = 4'b0001 << (k % 4);
      exp_data = 16'hA000 + 16'(k % 4);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got in_ready=%b expected %b", k, in_ready, exp_rdy);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(k % 4) || out_data !== exp_data) begin
        errors++;
        $display("FAIL rr_word[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 k, out_valid, out_chan, out_data, k % 4, exp_data);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 16'hA001 ||
          out_chan !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%h c=%0d expected rdy=0000 v=1 d=a001 c=1",
                 k, in_ready, out_valid, out_data, out_chan);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: got in_ready=%b expected 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 16'hA002) begin
      errors++;
      $display("FAIL bp_release_word: got v=%b c=%0d d=%h expected v=1 c=2 d=a002",
               out_valid, out_chan, out_data);
    end
    // Drain with no requests: valid falls, word held.
    in_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_chan !== 2'd2 || out_data !== 16'hA002) begin
      errors++;
      $display("FAIL drain_no_grant: got v=%b c=%0d d=%h expected v=0 c=2 d=a002",
               out_valid, out_chan, out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_sparse();
    do_reset();
    in_data   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    in_valid  = 4'b1111;
    rr_en     = 1'b1;
    out_ready = 1'b1;
    tick();  // ch0
    tick();  // ch1, ptr=1
    in_valid = 4'b1001;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL sparse_ready_ch3: got in_ready=%b expected 1000", in_ready);
    end
    tick();
    checks++;
    if (out_chan !== 2'd3 || out_data !== 16'hD003 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sparse_word_ch3: got c=%0d d=%h v=%b expected c=3 d=d003 v=1",
               out_chan, out_data, out_valid);
    end
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL sparse_ready_ch0: got in_ready=%b expected 0001", in_ready);
    end
    tick();
    checks++;
    if (out_chan !== 2'd0 || out_data !== 16'hD000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sparse_word_ch0: got c=%0d d=%h v=%b expected c=0 d=d000 v=1",
               out_chan, out_data, out_valid);
    end
    in_valid = 4'b0000;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_three_channel();
    do_reset();
    checks++;
    if (d3_out_valid !== 1'b0 || d3_in_ready !== 3'b000) begin
      errors++;
      $display("FAIL ch3_reset: got v=%b rdy=%b expected v=0 rdy=000",
               d3_out_valid, d3_in_ready);
    end
    d3_in_data   = {8'h5C, 8'h5B, 8'h5A};
    d3_in_valid  = 3'b111;
    d3_rr_en     = 1'b0;
    d3_sel       = 2'd1;
    d3_out_ready = 1'b1;
    tick();
    checks++;
    if (d3_out_valid !== 1'b1 || d3_out_chan !== 2'd1 || d3_out_data !== 8'h5B) begin
      errors++;
      $display("FAIL ch3_sel1_word: got v=%b c=%0d d=%h expected v=1 c=1 d=5b",
               d3_out_valid, d3_out_chan, d3_out_data);
    end
    d3_sel = 2'd3;
    #1;
    checks++;
    if (d3_in_ready !== 3'b000) begin
      errors++;
      $display("FAIL ch3_sel3_ready: got in_ready=%b expected 000", d3_in_ready);
    end
    tick();
    checks++;
    if (d3_out_valid !== 1'b0 || d3_out_chan !== 2'd1 || d3_out_data !== 8'h5B) begin
      errors++;
      $display("FAIL ch3_sel3_drain: got v=%b c=%0d d=%h expected v=0 c=1 d=5b",
               d3_out_valid, d3_out_chan, d3_out_data);
    end
    tick();
    checks++;
    if (d3_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ch3_sel3_stay_empty: got v=%b expected v=0", d3_out_valid);
    end
    // Round-robin on 3 channels wraps 2 -> 0 (ptr was 1).
    d3_rr_en = 1'b1;
    tick();
    checks++;
    if (d3_out_chan !== 2'd2 || d3_out_data !== 8'h5C) begin
      errors++;
      $display("FAIL ch3_rr_ch2: got c=%0d d=%h expected c=2 d=5c", d3_out_chan, d3_out_data);
    end
    tick();
    checks++;
    if (d3_out_chan !== 2'd0 || d3_out_data !== 8'h5A) begin
      errors++;
      $display("FAIL ch3_rr_wrap: got c=%0d d=%h expected c=0 d=5a", d3_out_chan, d3_out_data);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    checks       = 0;
    errors       = 0;
    d3_in_data   = '0;
    d3_in_valid  = '0;
    d3_rr_en     = 1'b0;
    d3_sel       = '0;
    d3_out_ready = 1'b1;

    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_three_channel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bus_mux_rr
`default_nettype wire
